// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
package seq_detect_pkg;

    localparam logic [15:0] DEFAULT_PAT = 16'h000B;

    localparam bit MODE_MOORE = 1'b0;
    localparam bit MODE_MEALY = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and active-low synchronous reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            // an increment landing on the clear cycle still counts once
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: run-time loadable pattern, overlap/non-overlap,
// Moore or Mealy match flag, saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(DEFAULT_PAT),
    parameter bit               OVERLAP   = 1'b1,
    parameter bit               MEALY     = MODE_MOORE,
    parameter int               CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic                         x_in,
    input  logic                         pat_load,
    input  logic [PAT_W-1:0]             pat_in,
    input  logic                         cnt_clr,
    output logic                         y_out,
    output logic [clog2(PAT_W+1)-1:0]    state,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int SW = clog2(PAT_W + 1);

    logic [PAT_W-1:0] pattern, pattern_nx;
    logic [PAT_W-1:0] hist, hist_nx, nhist;
    logic [SW-1:0]    state_nx;
    logic             hit;
    logic             y_reg;

    always_comb begin
        nhist      = {hist[PAT_W-2:0], x_in};
        hit        = en && !pat_load && (state >= SW'(PAT_W - 1)) && (nhist == pattern);
        pattern_nx = pattern;
        hist_nx    = hist;
        state_nx   = state;
        if (pat_load) begin
            pattern_nx = pat_in;
            hist_nx    = '0;
            state_nx   = '0;
        end else if (en) begin
            if (hit && !OVERLAP) begin
                hist_nx  = '0;
                state_nx = '0;
            end else begin
                // on an overlapping hit the fill count is already >= PAT_W-1,
                // so saturating increment lands on PAT_W
                hist_nx  = nhist;
                state_nx = (state == SW'(PAT_W)) ? state : state + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pattern <= RESET_PAT;
            hist    <= '0;
            state   <= '0;
            y_reg   <= 1'b0;
        end else begin
            pattern <= pattern_nx;
            hist    <= hist_nx;
            state   <= state_nx;
            y_reg   <= hit;
        end
    end

    assign y_out = (MEALY == MODE_MEALY) ? (rstn & hit) : y_reg;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (hit),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );

endmodule
